// File: rtl/riscv_pkg.sv
// Shared constants for the writeback stage: widths, register count,
// x0 address and the writeback source select encodings.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int NREGS      = 32;
   localparam int REG_ADDR_W = $clog2(NREGS);
   localparam int PEND_BITS  = 2;

   localparam logic [REG_ADDR_W-1:0] X0       = '0;
   localparam logic [PEND_BITS-1:0]  PEND_MAX = '1;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_DMEM = 2'b01;
   localparam logic [1:0] WB_SEL_PC4  = 2'b10;
   localparam logic [1:0] WB_SEL_IMM  = 2'b11;

endpackage

// File: rtl/wb_regfile_scoreboard_if.sv
// Bus between the pipeline (master) and the writeback/regfile block (slave):
// MEM/WB operands, ID read ports, issue request, stall and status outputs.
interface wb_regfile_scoreboard_if;
   import riscv_pkg::*;

   logic [REG_ADDR_W-1:0] WB_INSTRUCTION;
   logic [XLEN-1:0]       WB_PC_4;
   logic [XLEN-1:0]       WB_ALU_RESULT;
   logic [XLEN-1:0]       WB_IMMEDIATE;
   logic [XLEN-1:0]       WB_DMEM_OUT;
   logic [1:0]            WB_SEL;
   logic                  WB_REG_WRITE_EN;
   logic [REG_ADDR_W-1:0] RS1_ADDR;
   logic [REG_ADDR_W-1:0] RS2_ADDR;
   logic [XLEN-1:0]       RS1_DATA;
   logic [XLEN-1:0]       RS2_DATA;
   logic                  ISSUE_VALID;
   logic [REG_ADDR_W-1:0] ISSUE_RD;
   logic                  ISSUE_REG_WRITE_EN;
   logic                  RS1_BUSY;
   logic                  RS2_BUSY;
   logic                  STALL;
   logic [XLEN-1:0]       WB_DATA;
   logic [31:0]           RETIRE_COUNT;

   modport master (
      output WB_INSTRUCTION, WB_PC_4, WB_ALU_RESULT, WB_IMMEDIATE,
      output WB_DMEM_OUT, WB_SEL, WB_REG_WRITE_EN,
      output RS1_ADDR, RS2_ADDR,
      output ISSUE_VALID, ISSUE_RD, ISSUE_REG_WRITE_EN,
      input  RS1_DATA, RS2_DATA, RS1_BUSY, RS2_BUSY,
      input  STALL, WB_DATA, RETIRE_COUNT
   );

   modport slave (
      input  WB_INSTRUCTION, WB_PC_4, WB_ALU_RESULT, WB_IMMEDIATE,
      input  WB_DMEM_OUT, WB_SEL, WB_REG_WRITE_EN,
      input  RS1_ADDR, RS2_ADDR,
      input  ISSUE_VALID, ISSUE_RD, ISSUE_REG_WRITE_EN,
      output RS1_DATA, RS2_DATA, RS1_BUSY, RS2_BUSY,
      output STALL, WB_DATA, RETIRE_COUNT
   );

endinterface

// File: rtl/regfile_2r1w.sv
// 32 x XLEN register array: two async read ports, one sync write port.
// Ports: clk, rst (sync high), we/waddr/wdata, raddr1/2 -> rdata1/2. x0 reads 0.
module regfile_2r1w
   import riscv_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [XLEN-1:0]       wdata,
   input  logic [REG_ADDR_W-1:0] raddr1,
   input  logic [REG_ADDR_W-1:0] raddr2,
   output logic [XLEN-1:0]       rdata1,
   output logic [XLEN-1:0]       rdata2
);

   logic [XLEN-1:0] regs [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      end else if (we && waddr != X0) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == X0) ? '0 : regs[raddr1];
   assign rdata2 = (raddr2 == X0) ? '0 : regs[raddr2];

endmodule

// File: rtl/wb_regfile_scoreboard.sv
// Writeback stage: WB source mux, regfile write with read bypass,
// per-register pending-write scoreboard, ID stall and retire counter.
// Ports: CLK, RESET (sync high), bus (slave side of the WB/ID bus).
module wb_regfile_scoreboard
   import riscv_pkg::*;
(
   input logic                   CLK,
   input logic                   RESET,
   wb_regfile_scoreboard_if.slave bus
);

   logic [REG_ADDR_W-1:0] rd;
   logic                  wr;
   logic [XLEN-1:0]       wb_data;
   logic [XLEN-1:0]       rf_rdata1;
   logic [XLEN-1:0]       rf_rdata2;
   logic [PEND_BITS-1:0]  pend [NREGS];
   logic [31:0]           retire_cnt;
   logic                  hit1;
   logic                  hit2;
   logic                  busy1;
   logic                  busy2;
   logic                  rd_full;
   logic                  stall;
   logic                  inc;

   assign rd = bus.WB_INSTRUCTION;

   // === keeps an X enable (upstream reset state) from writing.
   assign wr = (bus.WB_REG_WRITE_EN === 1'b1) && (rd != X0) && !RESET;

   always_comb begin
      wb_data = bus.WB_ALU_RESULT;
      case (bus.WB_SEL)
         WB_SEL_ALU:  wb_data = bus.WB_ALU_RESULT;
         WB_SEL_DMEM: wb_data = bus.WB_DMEM_OUT;
         WB_SEL_PC4:  wb_data = bus.WB_PC_4;
         WB_SEL_IMM:  wb_data = bus.WB_IMMEDIATE;
         default:     wb_data = bus.WB_ALU_RESULT;
      endcase
   end

   regfile_2r1w u_rf (
      .clk    (CLK),
      .rst    (RESET),
      .we     (wr),
      .waddr  (rd),
      .wdata  (wb_data),
      .raddr1 (bus.RS1_ADDR),
      .raddr2 (bus.RS2_ADDR),
      .rdata1 (rf_rdata1),
      .rdata2 (rf_rdata2)
   );

   assign hit1 = wr && (bus.RS1_ADDR == rd);
   assign hit2 = wr && (bus.RS2_ADDR == rd);

   always_comb begin
      bus.RS1_DATA = rf_rdata1;
      bus.RS2_DATA = rf_rdata2;
      if (bus.RS1_ADDR == X0) bus.RS1_DATA = '0;
      else if (hit1)          bus.RS1_DATA = wb_data;
      if (bus.RS2_ADDR == X0) bus.RS2_DATA = '0;
      else if (hit2)          bus.RS2_DATA = wb_data;
   end

   // A write retiring this cycle already resolves one pending entry.
   assign busy1 = (bus.RS1_ADDR != X0) &&
                  ((pend[bus.RS1_ADDR] - PEND_BITS'(hit1)) != '0);
   assign busy2 = (bus.RS2_ADDR != X0) &&
                  ((pend[bus.RS2_ADDR] - PEND_BITS'(hit2)) != '0);

   // Counter for the issuing rd is full unless a writeback frees a slot now.
   assign rd_full = bus.ISSUE_REG_WRITE_EN && (bus.ISSUE_RD != X0) &&
                    (pend[bus.ISSUE_RD] == PEND_MAX) &&
                    !(wr && rd == bus.ISSUE_RD);

   assign stall = bus.ISSUE_VALID && (busy1 || busy2 || rd_full);

   assign inc = bus.ISSUE_VALID && bus.ISSUE_REG_WRITE_EN &&
                !stall && (bus.ISSUE_RD != X0);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int r = 0; r < NREGS; r++) pend[r] <= '0;
      end else begin
         pend[0] <= '0;
         for (int r = 1; r < NREGS; r++) begin
            if (inc && bus.ISSUE_RD == REG_ADDR_W'(r) &&
                !(wr && rd == REG_ADDR_W'(r))) begin
               pend[r] <= pend[r] + PEND_BITS'(1);
            end else if (wr && rd == REG_ADDR_W'(r) &&
                         !(inc && bus.ISSUE_RD == REG_ADDR_W'(r)) &&
                         pend[r] != '0) begin
               pend[r] <= pend[r] - PEND_BITS'(1);
            end
         end
      end
   end

   // Retiring a write with nothing pending means issue/writeback disagree.
   always_ff @(posedge CLK) begin
      if (!RESET && wr) begin
         assert (pend[rd] != '0)
         else $error("scoreboard underflow on x%0d", rd);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET)   retire_cnt <= '0;
      else if (wr) retire_cnt <= retire_cnt + 32'd1;
   end

   assign bus.RS1_BUSY     = busy1;
   assign bus.RS2_BUSY     = busy2;
   assign bus.STALL        = stall;
   assign bus.WB_DATA      = wb_data;
   assign bus.RETIRE_COUNT = retire_cnt;

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Bench for wb_regfile_scoreboard: directed steps plus random traffic
// against an array/counter reference model of the writeback stage.
module tb_wb_regfile_scoreboard;
   import riscv_pkg::*;

   logic CLK = 1'b0;
   logic RESET;

   always #5 CLK = ~CLK;

   wb_regfile_scoreboard_if wbif ();

   wb_regfile_scoreboard dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (wbif.slave)
   );

   logic [31:0] regs_m [32];
   int          pend_m [32];
   logic [31:0] cnt_m;
   int          passed = 0;
   int          total  = 0;
   logic [31:0] c_save;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic m_wr();
      return (wbif.WB_REG_WRITE_EN === 1'b1) &&
             (wbif.WB_INSTRUCTION != 5'd0) && (RESET === 1'b0);
   endfunction

   function automatic logic [31:0] m_wbdata();
      case (wbif.WB_SEL)
         2'b00:   return wbif.WB_ALU_RESULT;
         2'b01:   return wbif.WB_DMEM_OUT;
         2'b10:   return wbif.WB_PC_4;
         default: return wbif.WB_IMMEDIATE;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (m_wr() && a == wbif.WB_INSTRUCTION) return m_wbdata();
      return regs_m[a];
   endfunction

   function automatic logic m_busy(input logic [4:0] a);
      int left;
      if (a == 5'd0) return 1'b0;
      left = pend_m[a];
      if (m_wr() && a == wbif.WB_INSTRUCTION) left = left - 1;
      return left != 0;
   endfunction

   function automatic logic m_stall();
      logic full;
      full = wbif.ISSUE_REG_WRITE_EN && wbif.ISSUE_RD != 5'd0 &&
             pend_m[wbif.ISSUE_RD] == 3 &&
             !(m_wr() && wbif.WB_INSTRUCTION == wbif.ISSUE_RD);
      return wbif.ISSUE_VALID &&
             (m_busy(wbif.RS1_ADDR) || m_busy(wbif.RS2_ADDR) || full);
   endfunction

   task automatic idle();
      wbif.WB_INSTRUCTION     = '0;
      wbif.WB_PC_4            = '0;
      wbif.WB_ALU_RESULT      = '0;
      wbif.WB_IMMEDIATE       = '0;
      wbif.WB_DMEM_OUT        = '0;
      wbif.WB_SEL             = '0;
      wbif.WB_REG_WRITE_EN    = 1'b0;
      wbif.RS1_ADDR           = '0;
      wbif.RS2_ADDR           = '0;
      wbif.ISSUE_VALID        = 1'b0;
      wbif.ISSUE_RD           = '0;
      wbif.ISSUE_REG_WRITE_EN = 1'b0;
   endtask

   task automatic wb(input logic [4:0] r, input logic [1:0] sel,
                     input logic [31:0] d);
      wbif.WB_INSTRUCTION  = r;
      wbif.WB_SEL          = sel;
      wbif.WB_REG_WRITE_EN = 1'b1;
      wbif.WB_ALU_RESULT   = $urandom;
      wbif.WB_DMEM_OUT     = $urandom;
      wbif.WB_PC_4         = $urandom;
      wbif.WB_IMMEDIATE    = $urandom;
      case (sel)
         2'b00:   wbif.WB_ALU_RESULT = d;
         2'b01:   wbif.WB_DMEM_OUT   = d;
         2'b10:   wbif.WB_PC_4       = d;
         default: wbif.WB_IMMEDIATE  = d;
      endcase
   endtask

   task automatic issue(input logic [4:0] r);
      wbif.ISSUE_VALID        = 1'b1;
      wbif.ISSUE_RD           = r;
      wbif.ISSUE_REG_WRITE_EN = 1'b1;
   endtask

   task automatic tick();
      logic        w;
      logic        inc;
      logic [4:0]  r;
      logic [4:0]  ir;
      logic [31:0] d;
      w   = m_wr();
      r   = wbif.WB_INSTRUCTION;
      ir  = wbif.ISSUE_RD;
      d   = m_wbdata();
      inc = wbif.ISSUE_VALID && wbif.ISSUE_REG_WRITE_EN &&
            !m_stall() && ir != 5'd0;
      @(posedge CLK);
      if (RESET) begin
         for (int i = 0; i < 32; i++) begin
            regs_m[i] = '0;
            pend_m[i] = 0;
         end
         cnt_m = '0;
      end else begin
         if (w) begin
            regs_m[r] = d;
            cnt_m     = cnt_m + 32'd1;
            if (pend_m[r] > 0) pend_m[r] = pend_m[r] - 1;
         end
         if (inc) pend_m[ir] = pend_m[ir] + 1;
      end
      @(negedge CLK);
   endtask

   task automatic step(input string tag);
      #1;
      check({tag, ".rs1_data"}, wbif.RS1_DATA, m_read(wbif.RS1_ADDR));
      check({tag, ".rs2_data"}, wbif.RS2_DATA, m_read(wbif.RS2_ADDR));
      check({tag, ".rs1_busy"}, 32'(wbif.RS1_BUSY), 32'(m_busy(wbif.RS1_ADDR)));
      check({tag, ".rs2_busy"}, 32'(wbif.RS2_BUSY), 32'(m_busy(wbif.RS2_ADDR)));
      check({tag, ".stall"}, 32'(wbif.STALL), 32'(m_stall()));
      if (wbif.WB_REG_WRITE_EN === 1'b1)
         check({tag, ".wb_data"}, wbif.WB_DATA, m_wbdata());
      check({tag, ".retire"}, wbif.RETIRE_COUNT, cnt_m);
      tick();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         regs_m[i] = '0;
         pend_m[i] = 0;
      end
      cnt_m = '0;
      RESET = 1'b1;
      idle();
      @(negedge CLK);
      tick();
      tick();
      RESET = 1'b0;

      for (int a = 1; a < 32; a++) begin
         wbif.RS1_ADDR = 5'(a);
         wbif.RS2_ADDR = 5'(32 - a);
         #1;
         check("reset.rs1_data", wbif.RS1_DATA, 32'd0);
         check("reset.rs2_busy", 32'(wbif.RS2_BUSY), 32'd0);
      end
      check("reset.stall", 32'(wbif.STALL), 32'd0);
      check("reset.retire", wbif.RETIRE_COUNT, 32'd0);

      idle();
      issue(5'd5);
      step("mux.issue");
      for (int k = 0; k < 4; k++) begin
         idle();
         wb(5'd5, 2'(k), 32'h11 * 32'(k + 1));
         if (k < 3) issue(5'd5);
         wbif.RS2_ADDR = 5'd5;
         #1;
         check("mux.bypass", wbif.RS2_DATA, 32'h11 * 32'(k + 1));
         step("mux");
      end
      idle();
      wbif.RS1_ADDR = 5'd5;
      #1;
      check("mux.array", wbif.RS1_DATA, 32'h44);
      step("mux.read");

      idle();
      issue(5'd7);
      step("byp.issue");
      idle();
      wb(5'd7, WB_SEL_ALU, 32'hDEADBEEF);
      wbif.RS1_ADDR = 5'd7;
      #1;
      check("byp.same_cycle", wbif.RS1_DATA, 32'hDEADBEEF);
      step("byp");
      idle();
      c_save = wbif.RETIRE_COUNT;
      wb(5'd0, WB_SEL_ALU, 32'hFFFFFFFF);
      #1;
      check("x0.read", wbif.RS1_DATA, 32'd0);
      step("x0");
      check("x0.retire", wbif.RETIRE_COUNT, c_save);

      idle();
      issue(5'd3);
      step("sb.issue");
      idle();
      issue(5'd10);
      wbif.RS2_ADDR = 5'd3;
      #1;
      check("sb.busy", 32'(wbif.RS2_BUSY), 32'd1);
      check("sb.stall", 32'(wbif.STALL), 32'd1);
      step("sb.hold");
      idle();
      issue(5'd10);
      wb(5'd3, WB_SEL_DMEM, 32'h1234);
      wbif.RS2_ADDR = 5'd3;
      #1;
      check("sb.clear_busy", 32'(wbif.RS2_BUSY), 32'd0);
      check("sb.clear_stall", 32'(wbif.STALL), 32'd0);
      step("sb.wb");

      for (int k = 0; k < 3; k++) begin
         idle();
         issue(5'd4);
         step("sat.issue");
      end
      idle();
      issue(5'd4);
      #1;
      check("sat.stall", 32'(wbif.STALL), 32'd1);
      step("sat.full");
      check("sat.pend_hold", 32'(dut.pend[4]), 32'd3);
      idle();
      issue(5'd4);
      wb(5'd4, WB_SEL_IMM, 32'h55);
      #1;
      check("sat.swap_stall", 32'(wbif.STALL), 32'd0);
      step("sat.swap");
      check("sat.pend_swap", 32'(dut.pend[4]), 32'd3);

      idle();
      c_save = wbif.RETIRE_COUNT;
      wbif.WB_INSTRUCTION  = 5'd6;
      wbif.WB_ALU_RESULT   = 32'h66;
      wbif.WB_REG_WRITE_EN = 1'bx;
      step("xen");
      idle();
      wbif.RS1_ADDR = 5'd6;
      #1;
      check("xen.no_write", wbif.RS1_DATA, 32'd0);
      check("xen.retire", wbif.RETIRE_COUNT, c_save);

      idle();
      force dut.retire_cnt = 32'hFFFFFFFF;
      #1;
      release dut.retire_cnt;
      cnt_m = 32'hFFFFFFFF;
      wb(5'd4, WB_SEL_PC4, 32'h77);
      step("wrap.pre");
      check("wrap.zero", wbif.RETIRE_COUNT, 32'd0);

      idle();
      issue(5'd9);
      step("rst.issue1");
      idle();
      issue(5'd9);
      step("rst.issue2");
      check("rst.pend9", 32'(dut.pend[9]), 32'd2);
      idle();
      RESET = 1'b1;
      issue(5'd12);
      tick();
      RESET = 1'b0;
      idle();
      wbif.RS1_ADDR = 5'd9;
      #1;
      check("rst.busy9", 32'(wbif.RS1_BUSY), 32'd0);
      check("rst.retire", wbif.RETIRE_COUNT, 32'd0);
      step("rst.after");

      for (int n = 0; n < 400; n++) begin
         logic [4:0] r;
         idle();
         wbif.RS1_ADDR = 5'($urandom_range(0, 31));
         wbif.RS2_ADDR = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) begin
            wbif.RS1_ADDR = '0;
            wbif.RS2_ADDR = '0;
         end
         if ($urandom_range(0, 1) == 1) begin
            wbif.ISSUE_VALID        = 1'b1;
            wbif.ISSUE_RD           = 5'($urandom_range(0, 31));
            wbif.ISSUE_REG_WRITE_EN = ($urandom_range(0, 4) != 0);
         end
         r = 5'($urandom_range(0, 31));
         if (r == 5'd0 || pend_m[r] > 0)
            wb(r, 2'($urandom_range(0, 3)), $urandom);
         step("rand");
      end

      for (int r = 1; r < 32; r++)
         check("final.pend", 32'(dut.pend[r]), 32'(pend_m[r]));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
